// File: rtl/fifo_pkg.sv
// Shared types, defaults and sizing helper for the sync_fifo_param family.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int clog2_depth(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register-array RAM: one write port, one registered read port.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = clog2_depth(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // A read of the address being written returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int AW       = clog2_depth(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH outside 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH outside 0..DEPTH");
    end

    localparam fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  (AF_THRESH == 0),
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]     count_reg, count_next;
    fifo_status_t      status_reg, status_next;
    logic              rd_acc, wr_acc;
    logic              mem_we, mem_re;
    logic [AW-1:0]     mem_raddr;
    logic [DATA_W-1:0] mem_q;

    assign rd_acc = rd_en && !status_reg.empty;
    assign wr_acc = wr_en && (!status_reg.full || rd_acc);

    always_comb begin
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Flags come from the next-state count so they move on the same edge as count.
    always_comb begin
        status_next              = STATUS_RST;
        status_next.full         = (int'(count_next) == DEPTH);
        status_next.empty        = (count_next == '0);
        status_next.almost_full  = (int'(count_next) >= AF_THRESH);
        status_next.almost_empty = (int'(count_next) <= AE_THRESH);
        status_next.overflow     = wr_en && !wr_acc;
        status_next.underflow    = rd_en && !rd_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            status_reg <= STATUS_RST;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            status_reg <= status_next;
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_en   (mem_re),
        .rd_addr (mem_raddr),
        .rd_data (mem_q)
    );

`ifdef FIFO_FWFT_EN
    // The output register holds the head word and is counted in count;
    // the RAM holds the remaining count-1 words.
    logic              mem_low, bypass, refill;
    logic              fwd_sel_reg;
    logic [DATA_W-1:0] fwd_data_reg, out_data_reg, head;

    assign mem_low     = (count_reg <= CW'(1));
    assign bypass      = wr_acc && (status_reg.empty || (rd_acc && mem_low));
    assign refill      = rd_acc && !mem_low;
    assign mem_we      = wr_acc && !bypass;
    assign mem_re      = 1'b1;
    assign wr_ptr_next = wr_ptr_reg + AW'(mem_we);
    assign rd_ptr_next = rd_ptr_reg + AW'(refill);
    assign mem_raddr   = rd_ptr_next;

    // The RAM returns the old word when its prefetch address is written on
    // the same edge, so that word is forwarded from a side register instead.
    assign head = fwd_sel_reg ? fwd_data_reg : mem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_reg <= '0;
            fwd_sel_reg  <= 1'b0;
            fwd_data_reg <= '0;
        end else begin
            if (bypass) begin
                out_data_reg <= wr_data;
            end else if (refill) begin
                out_data_reg <= head;
            end
            fwd_sel_reg  <= mem_we && (wr_ptr_reg == rd_ptr_next);
            fwd_data_reg <= wr_data;
        end
    end

    assign rd_valid = !status_reg.empty;
    assign rd_data  = out_data_reg;
`else
    logic rd_valid_reg, rd_seen_reg;

    assign mem_we      = wr_acc;
    assign mem_re      = rd_acc;
    assign mem_raddr   = rd_ptr_reg;
    assign wr_ptr_next = wr_ptr_reg + AW'(wr_acc);
    assign rd_ptr_next = rd_ptr_reg + AW'(rd_acc);

    // The RAM read register is not reset; rd_seen masks it to zero until the first pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_reg <= 1'b0;
            rd_seen_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= rd_acc;
            if (rd_acc) begin
                rd_seen_reg <= 1'b1;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_seen_reg ? mem_q : '0;
`endif

    assign count        = count_reg;
    assign full         = status_reg.full;
    assign empty        = status_reg.empty;
    assign almost_full  = status_reg.almost_full;
    assign almost_empty = status_reg.almost_empty;
    assign overflow     = status_reg.overflow;
    assign underflow    = status_reg.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (DATA_W=8, DEPTH=16); FIFO_FWFT_EN selects the FWFT sequence.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    sync_fifo_param dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".count"}, int'(count), 0);
        chk({tag, ".full"}, int'(full), 0);
        chk({tag, ".empty"}, int'(empty), 1);
        chk({tag, ".almost_full"}, int'(almost_full), 0);
        chk({tag, ".almost_empty"}, int'(almost_empty), 1);
        chk({tag, ".rd_valid"}, int'(rd_valid), 0);
        chk({tag, ".rd_data"}, int'(rd_data), 0);
        chk({tag, ".overflow"}, int'(overflow), 0);
        chk({tag, ".underflow"}, int'(underflow), 0);
    endtask

`ifdef FIFO_FWFT_EN
    // Head word is compared at the moment it is popped.
    always @(negedge clk) begin
        if (rst && rd_en && rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop: got word %0h, required no word", rd_data);
            end else begin
                chk("pop.rd_data", int'(rd_data), int'(sb.pop_front()));
            end
        end
    end
`else
    // Each rd_valid cycle must deliver the next queued word.
    always @(negedge clk) begin
        if (rst && rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid: got word %0h, required no word", rd_data);
            end else begin
                chk("mon.rd_data", int'(rd_data), int'(sb.pop_front()));
            end
        end
    end
`endif

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, required finish within 50000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b1;

`ifdef FIFO_FWFT_EN
        step(1'b1, 8'hA5, 1'b0);
        chk("fwft.rd_valid", int'(rd_valid), 1);
        chk("fwft.rd_data", int'(rd_data), 8'hA5);
        chk("fwft.count", int'(count), 1);
        sb.push_back(8'hA5);
        step(1'b0, 8'h00, 1'b1);
        chk("fwft.pop.empty", int'(empty), 1);
        chk("fwft.pop.rd_valid", int'(rd_valid), 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'(8'hB1 + k), 1'b0);
        end
        chk("fwft.fill.count", int'(count), 3);
        chk("fwft.fill.rd_data", int'(rd_data), 8'hB1);
        sb.push_back(8'hB1);
        sb.push_back(8'hB2);
        sb.push_back(8'hB3);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b1);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("fwft.drain.empty", int'(empty), 1);
        chk("fwft.drain.count", int'(count), 0);
`else
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h11 + i), 1'b0);
            chk("fill.count", int'(count), i + 1);
            chk("fill.almost_full", int'(almost_full), int'((i + 1) >= 14));
            chk("fill.almost_empty", int'(almost_empty), int'((i + 1) <= 2));
            chk("fill.full", int'(full), int'(i == 15));
        end

        step(1'b1, 8'h99, 1'b0);
        chk("ovf.overflow", int'(overflow), 1);
        chk("ovf.count", int'(count), 16);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf.pulse_end", int'(overflow), 0);

        // Full with simultaneous push/pop: 16 original words, then the first four new ones.
        for (int k = 0; k < 20; k++) begin
            sb.push_back((k < 16) ? 8'(8'h11 + k) : 8'(8'h30 + k - 16));
            step(1'b1, 8'(8'h30 + k), 1'b1);
            chk("wrrd.count", int'(count), 16);
            chk("wrrd.full", int'(full), 1);
            chk("wrrd.overflow", int'(overflow), 0);
        end

        for (int k = 0; k < 16; k++) begin
            sb.push_back(8'(8'h34 + k));
            step(1'b0, 8'h00, 1'b1);
            chk("drain.count", int'(count), 15 - k);
        end
        chk("drain.empty", int'(empty), 1);
        chk("drain.almost_empty", int'(almost_empty), 1);
        chk("drain.full", int'(full), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("hold.rd_valid", int'(rd_valid), 0);
        chk("hold.rd_data", int'(rd_data), 8'h43);

        step(1'b0, 8'h00, 1'b1);
        chk("udf.underflow", int'(underflow), 1);
        chk("udf.rd_valid", int'(rd_valid), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("udf.pulse_end", int'(underflow), 0);

        step(1'b1, 8'h55, 1'b1);
        chk("emptywr.count", int'(count), 1);
        chk("emptywr.underflow", int'(underflow), 1);
        chk("emptywr.rd_valid", int'(rd_valid), 0);
        sb.push_back(8'h55);
        step(1'b0, 8'h00, 1'b1);
        chk("emptywr.pop.rd_valid", int'(rd_valid), 1);
        chk("emptywr.pop.count", int'(count), 0);
        step(1'b0, 8'h00, 1'b0);

        for (int k = 0; k < 5; k++) begin
            step(1'b1, 8'(8'h61 + k), 1'b0);
        end
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        chk("in_rst.count", int'(count), 0);
        rst = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        chk("post_rst.count", int'(count), 1);
        sb.push_back(8'h77);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst.empty", int'(empty), 1);
`endif

        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
